mem_store_buffered: RTL

Memory-access stage that succeeds the single-cache MEM stage. Stores post into a parametrised store buffer and return without stalling; the buffer drains to external memory over a req/ack handshake. Loads take priority over draining, are checked for address hazards against the buffer, and are byte/half/word extended. The block sits between EX and WB and drives the data-memory port directly.

---
 rtl/mem_store_buffered.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_store_buffered.sv
// MEM stage with a circular store buffer that drains over a req/ack port while loads
// take priority. Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning down.
module mem_store_buffered #(
  parameter int ADDR_W     = 32,
  parameter int SBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       AluResult,
  input  logic [31:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        LS_op,
  output logic [31:0]       Result,
  output logic              Stall,
  output logic              SbEmpty,
  output logic              MisalignExc,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWriteData,
  output logic [3:0]        MemByteEn,
  input  logic              MemAck,
  input  logic [31:0]       MemData
);

  localparam int PTR_W = $clog2(SBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_LD_WAIT, S_ST_WAIT, S_LD_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WA_W-1:0]       r_sb_addr [SBUF_DEPTH];
  logic [31:0]           r_sb_data [SBUF_DEPTH];
  logic [3:0]            r_sb_be   [SBUF_DEPTH];
  logic [SBUF_DEPTH-1:0] r_sb_vld;
  logic [SBUF_DEPTH-1:0] w_vld_nxt;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [31:0]           r_ld_data;
  logic [1:0]            r_ld_off;
  logic [2:0]            r_ld_op;

  logic              w_is_byte;
  logic              w_is_half;
  logic              w_drop;
  logic [1:0]        w_off;
  logic [WA_W-1:0]   w_word;
  logic [31:0]       w_st_data;
  logic [3:0]        w_st_be;
  logic              w_hazard;
  logic              w_ld_pend;
  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;
  logic              w_ld_cap;
  logic              w_req;
  logic              w_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [31:0]       w_req_data;
  logic [3:0]        w_req_be;

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] off,
                                              input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (op[1:0])
      2'b00:   return op[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return op[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  assign w_is_byte = (LS_op[1:0] == 2'b00);
  assign w_is_half = (LS_op[1:0] == 2'b01);
  assign w_word    = AluResult[ADDR_W-1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign  = (MemRead | MemWrite) &
                       ((w_is_half & AluResult[0]) |
                        (~w_is_byte & ~w_is_half & (AluResult[1:0] != 2'b00)));
  assign w_drop      = w_misalign;
  assign w_off       = AluResult[1:0];
  assign MisalignExc = rst & w_misalign;
`else
  assign w_drop      = 1'b0;
  assign w_off       = w_is_byte ? AluResult[1:0] :
                       w_is_half ? {AluResult[1], 1'b0} : 2'b00;
  assign MisalignExc = 1'b0;
`endif

  // Stores are lane-replicated so the byte enables alone pick the target bytes
  always_comb begin
    w_st_be   = 4'b1111;
    w_st_data = WriteData;
    if (w_is_byte) begin
      w_st_be   = 4'b0001 << w_off;
      w_st_data = {4{WriteData[7:0]}};
    end else if (w_is_half) begin
      w_st_be   = 4'b0011 << w_off;
      w_st_data = {2{WriteData[15:0]}};
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < SBUF_DEPTH; i++) begin
      if (r_sb_vld[i] && (r_sb_addr[i] == w_word)) w_hazard = 1'b1;
    end
  end

  assign w_ld_pend = MemRead & ~w_drop;
  assign w_full    = (r_count == CNT_W'(SBUF_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_enq     = rst & MemWrite & ~w_drop & (~w_full | w_deq);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_req_addr  = '0;
    w_req_data  = '0;
    w_req_be    = '0;
    w_deq       = 1'b0;
    w_ld_cap    = 1'b0;
    if (rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_ld_pend && !w_hazard) begin
            w_req      = 1'b1;
            w_req_addr = {w_word, 2'b00};
            if (MemAck) begin
              w_ld_cap    = 1'b1;
              w_state_nxt = S_LD_RESP;
            end else begin
              w_state_nxt = S_LD_WAIT;
            end
          end else if (!w_empty) begin
            w_req      = 1'b1;
            w_we       = 1'b1;
            w_req_addr = {r_sb_addr[r_head], 2'b00};
            w_req_data = r_sb_data[r_head];
            w_req_be   = r_sb_be[r_head];
            if (MemAck) w_deq = 1'b1;
            else        w_state_nxt = S_ST_WAIT;
          end
        end
        S_LD_WAIT: begin
          w_req      = 1'b1;
          w_req_addr = {w_word, 2'b00};
          if (MemAck) begin
            w_ld_cap    = 1'b1;
            w_state_nxt = S_LD_RESP;
          end
        end
        S_ST_WAIT: begin
          w_req      = 1'b1;
          w_we       = 1'b1;
          w_req_addr = {r_sb_addr[r_head], 2'b00};
          w_req_data = r_sb_data[r_head];
          w_req_be   = r_sb_be[r_head];
          if (MemAck) begin
            w_deq       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Clear the dequeued slot before setting the enqueued one: they coincide when full
  always_comb begin
    w_vld_nxt = r_sb_vld;
    if (w_deq) w_vld_nxt[r_head] = 1'b0;
    if (w_enq) w_vld_nxt[r_tail] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_sb_vld <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sb_vld <= w_vld_nxt;
      if (w_deq) r_head <= r_head + PTR_W'(1);
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_sb_addr[r_tail] <= w_word;
      r_sb_data[r_tail] <= w_st_data;
      r_sb_be[r_tail]   <= w_st_be;
    end
    if (w_ld_cap) begin
      r_ld_data <= MemData;
      r_ld_off  <= w_off;
      r_ld_op   <= LS_op;
    end
  end

  assign MemReq       = w_req;
  assign MemWe        = w_we;
  assign MemAddr      = w_req_addr;
  assign MemWriteData = w_req_data;
  assign MemByteEn    = w_req_be;
  assign Stall        = rst & ((w_ld_pend & (r_state != S_LD_RESP)) |
                               (MemWrite & ~w_drop & w_full & ~w_deq));
  assign Result       = (rst && (r_state == S_LD_RESP)) ?
                        load_extend(r_ld_data, r_ld_off, r_ld_op) : AluResult;
  assign SbEmpty      = w_empty & (r_state != S_ST_WAIT);

endmodule
